// File: rtl/prm_edge_mask_engine_if.sv
// Occupancy-in / edge-mask-out stream bundle for prm_edge_mask_engine.
// The engine uses the slave view; the producer/consumer pair uses the master view.
interface prm_edge_mask_engine_if #(
   parameter int IN_W    = 15,
   parameter int N_EDGES = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [IN_W-1:0]    in_vec;
   logic               out_valid;
   logic               out_ready;
   logic [N_EDGES-1:0] out_mask;

   modport master (
      output in_valid, in_vec, out_ready,
      input  in_ready, out_valid, out_mask
   );

   modport slave (
      input  in_valid, in_vec, out_ready,
      output in_ready, out_valid, out_mask
   );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// Table-driven PRM edge-mask evaluator: ORs sum-of-products cubes per edge
// against one latched occupancy vector, one cube per clock.
module prm_edge_mask_engine #(
   parameter int IN_W    = 15,
   parameter int N_EDGES = 8,
   parameter int DEPTH   = 256,
   parameter int AW      = $clog2(DEPTH),
   parameter int EW      = (N_EDGES > 1) ? $clog2(N_EDGES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [AW-1:0]   cfg_addr,
   input  logic [IN_W-1:0] cfg_care,
   input  logic [IN_W-1:0] cfg_val,
   input  logic [EW-1:0]   cfg_edge,
   input  logic            cfg_count_we,
   input  logic [AW:0]     cfg_count,
   output logic            cfg_err,
   prm_edge_mask_engine_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

   localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   state_e             state_q, state_d;
   logic [IN_W-1:0]    vec_q, vec_d;
   logic [AW-1:0]      idx_q, idx_d;
   logic [N_EDGES-1:0] acc_q, acc_d;
   logic [AW:0]        count_q, count_d;
   logic               cfg_err_q, cfg_err_d;

   // Cube table: contents survive reset; count_q=0 keeps stale entries inert.
   logic [IN_W-1:0] care_mem [DEPTH];
   logic [IN_W-1:0] val_mem  [DEPTH];
   logic [EW-1:0]   edge_mem [DEPTH];

   logic [IN_W-1:0]    ent_care;
   logic [IN_W-1:0]    ent_val;
   logic [EW-1:0]      ent_edge;
   logic               cube_match;
   logic [N_EDGES-1:0] hit_vec;
   logic               cfg_allowed;
   logic               cfg_any;
   logic [AW:0]        count_clamped;
   logic               scan_last;

   assign ent_care   = care_mem[idx_q];
   assign ent_val    = val_mem[idx_q];
   assign ent_edge   = edge_mem[idx_q];
   assign cube_match = ((vec_q ^ ent_val) & ent_care) == '0;

   // Decoding only ids 0..N_EDGES-1 makes out-of-range edge ids silently inert.
   generate
      for (genvar gi = 0; gi < N_EDGES; gi++) begin : g_hit
         assign hit_vec[gi] = cube_match && (ent_edge == EW'(gi));
      end
   endgenerate

   assign cfg_allowed   = (state_q == IDLE);
   assign cfg_any       = cfg_we | cfg_count_we;
   assign count_clamped = (cfg_count > CNT_MAX) ? CNT_MAX : cfg_count;
   assign scan_last     = ({1'b0, idx_q} == (count_q - CNT_ONE));

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      count_d   = count_q;
      cfg_err_d = cfg_any && !cfg_allowed;

      if (cfg_count_we && cfg_allowed) begin
         count_d = count_clamped;
      end

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               vec_d = bus.in_vec;
               idx_d = '0;
               acc_d = '0;
               // A count written in the accept cycle already governs this scan.
               state_d = (count_d != '0) ? SCAN : DONE;
            end
         end
         SCAN: begin
            acc_d = acc_q | hit_vec;
            idx_d = idx_q + AW'(1);
            if (scan_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vec_q     <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vec_q     <= vec_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_we && cfg_allowed && !rst) begin
         care_mem[cfg_addr] <= cfg_care;
         val_mem[cfg_addr]  <= cfg_val;
         edge_mem[cfg_addr] <= cfg_edge;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_mask  = (state_q == DONE) ? acc_q : '0;
   assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Scenario bench for prm_edge_mask_engine: expected masks are queued at drive
// time and popped when the engine presents a result.
module tb_prm_edge_mask_engine;
   localparam int IN_W    = 15;
   localparam int N_EDGES = 8;
   localparam int DEPTH   = 256;
   localparam int AW      = 8;
   localparam int EW      = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_we;
   logic [AW-1:0]   cfg_addr;
   logic [IN_W-1:0] cfg_care;
   logic [IN_W-1:0] cfg_val;
   logic [EW-1:0]   cfg_edge;
   logic            cfg_count_we;
   logic [AW:0]     cfg_count;
   logic            cfg_err;

   always #5 clk = ~clk;

   prm_edge_mask_engine_if #(.IN_W(IN_W), .N_EDGES(N_EDGES)) bus_if ();

   prm_edge_mask_engine #(.IN_W(IN_W), .N_EDGES(N_EDGES), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_care     (cfg_care),
      .cfg_val      (cfg_val),
      .cfg_edge     (cfg_edge),
      .cfg_count_we (cfg_count_we),
      .cfg_count    (cfg_count),
      .cfg_err      (cfg_err),
      .bus          (bus_if)
   );

   int errors = 0;
   int checks = 0;
   logic [N_EDGES-1:0] exp_q [$];
   int                 lat_q [$];

   // Reference table mirror, updated only by writes the engine must accept.
   logic [IN_W-1:0] m_care [DEPTH];
   logic [IN_W-1:0] m_val  [DEPTH];
   int              m_edge [DEPTH];
   int              m_count = 0;

   function automatic logic [N_EDGES-1:0] model_eval(input logic [IN_W-1:0] v);
      logic [N_EDGES-1:0] m = '0;
      for (int i = 0; i < m_count; i++) begin
         if ((((v ^ m_val[i]) & m_care[i]) == '0) && (m_edge[i] < N_EDGES)) m[m_edge[i]] = 1'b1;
      end
      return m;
   endfunction

   task automatic cfg_write(input int addr, input logic [IN_W-1:0] care, input logic [IN_W-1:0] val,
                            input int edge_id);
      cfg_we   = 1'b1;
      cfg_addr = addr[AW-1:0];
      cfg_care = care;
      cfg_val  = val;
      cfg_edge = edge_id[EW-1:0];
      @(posedge clk); #1;
      cfg_we = 1'b0;
      m_care[addr] = care;
      m_val[addr]  = val;
      m_edge[addr] = edge_id;
   endtask

   task automatic set_count(input int c);
      cfg_count_we = 1'b1;
      cfg_count    = c[AW:0];
      @(posedge clk); #1;
      cfg_count_we = 1'b0;
      m_count = (c > DEPTH) ? DEPTH : c;
   endtask

   // Drives one accept (optionally with a same-cycle count write), waits for the result, completes the handshake.
   task automatic do_eval(input logic [IN_W-1:0] v, input int cnt_with,
                          output logic [N_EDGES-1:0] mask, output int lat, output bit tmo);
      bus_if.in_valid = 1'b1;
      bus_if.in_vec   = v;
      if (cnt_with >= 0) begin
         cfg_count_we = 1'b1;
         cfg_count    = cnt_with[AW:0];
      end
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      cfg_count_we    = 1'b0;
      lat = 1;
      tmo = 1'b0;
      while (!bus_if.out_valid && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      tmo  = !bus_if.out_valid;
      mask = bus_if.out_mask;
      bus_if.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.out_ready = 1'b0;
      $display("eval vec=%h mask=%h latency=%0d", v, mask, lat);
   endtask

   task automatic test_reset();
      logic [N_EDGES-1:0] got;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready); end
      checks++;
      if (bus_if.out_valid !== 1'b0 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL reset_outputs: out_valid=%b cfg_err=%b want 0 0", bus_if.out_valid, cfg_err);
      end
      got = bus_if.out_mask;
      checks++;
      if (got !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h want 00", got); end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus_if.in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_empty();
      logic [N_EDGES-1:0] got, exp;
      int lat, elat;
      bit tmo;
      exp_q.push_back(8'h00); lat_q.push_back(1);
      do_eval(15'h7FFF, -1, got, lat, tmo);
      exp = exp_q.pop_front(); elat = lat_q.pop_front();
      checks++;
      if (tmo || got !== exp) begin errors++; $display("FAIL empty_mask: got %h (timeout=%0b) want %h", got, tmo, exp); end
      checks++;
      if (lat != elat) begin errors++; $display("FAIL empty_latency: got %0d want %0d", lat, elat); end
   endtask

   task automatic test_single_cube();
      logic [N_EDGES-1:0] got, exp;
      int lat, elat;
      bit tmo;
      logic [IN_W-1:0] vecs [2];
      logic [N_EDGES-1:0] masks [2];
      vecs[0] = 15'h6120; masks[0] = 8'h08;
      vecs[1] = 15'h6121; masks[1] = 8'h00;
      cfg_write(0, 15'h61EF, 15'h6120, 3);
      set_count(1);
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(masks[k]); lat_q.push_back(2);
         do_eval(vecs[k], -1, got, lat, tmo);
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++;
         if (tmo || got !== exp) begin errors++; $display("FAIL single_mask[%0d]: got %h want %h", k, got, exp); end
         checks++;
         if (lat != elat) begin errors++; $display("FAIL single_latency[%0d]: got %0d want %0d", k, lat, elat); end
      end
   endtask

   task automatic test_multi_edge();
      logic [N_EDGES-1:0] got, exp;
      int lat, elat;
      bit tmo;
      logic [IN_W-1:0] vecs [3];
      vecs[0] = 15'h0000; vecs[1] = 15'h7FFF; vecs[2] = 15'h4A5A;
      cfg_write(0, 15'h0000, 15'h0000, 0);
      cfg_write(1, 15'h4000, 15'h0000, 5);
      cfg_write(2, 15'h4000, 15'h4000, 5);
      set_count(3);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(8'h21); lat_q.push_back(4);
         do_eval(vecs[k], -1, got, lat, tmo);
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++;
         if (tmo || got !== exp) begin errors++; $display("FAIL multi_mask[%0d]: got %h want %h", k, got, exp); end
         checks++;
         if (lat != elat) begin errors++; $display("FAIL multi_latency[%0d]: got %0d want %0d", k, lat, elat); end
      end
   endtask

   task automatic test_backpressure();
      logic [N_EDGES-1:0] first, exp;
      int n;
      exp_q.push_back(8'h21);
      bus_if.in_valid = 1'b1;
      bus_if.in_vec   = 15'h1234;
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      n = 0;
      while (!bus_if.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      first = bus_if.out_mask;
      exp = exp_q.pop_front();
      checks++;
      if (!bus_if.out_valid || first !== exp) begin
         errors++; $display("FAIL bp_first: valid=%b mask=%h want 1 %h", bus_if.out_valid, first, exp);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus_if.out_valid !== 1'b1 || bus_if.out_mask !== exp || bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b mask=%h in_ready=%b want 1 %h 0", c, bus_if.out_valid,
                     bus_if.out_mask, bus_if.in_ready, exp);
         end
      end
      bus_if.out_ready = 1'b1;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_ready: got %b want 0", bus_if.in_ready); end
      @(posedge clk); #1;
      bus_if.out_ready = 1'b0;
      checks++;
      if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", bus_if.in_ready, bus_if.out_valid);
      end
      $display("backpressure eval mask=%h held 10 cycles", first);
   endtask

   task automatic test_cfg_busy();
      logic [N_EDGES-1:0] got, exp;
      int lat, n;
      bit tmo;
      logic [IN_W-1:0] vecs [2];
      logic [N_EDGES-1:0] masks [2];
      vecs[0] = 15'h0000; masks[0] = 8'h21;
      vecs[1] = 15'h0001; masks[1] = 8'h25;
      cfg_write(0, 15'h0001, 15'h0001, 2);
      exp_q.push_back(8'h24);
      bus_if.in_valid = 1'b1;
      bus_if.in_vec   = 15'h0001;
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      @(posedge clk); #1;
      // Second scan cycle: attempt to overwrite entry 0 and the count.
      cfg_we = 1'b1; cfg_addr = 8'd0; cfg_care = 15'h0000; cfg_val = 15'h0000; cfg_edge = 3'd7;
      cfg_count_we = 1'b1; cfg_count = 9'd1;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_count_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL busy_cfg_err_pulse: got %b want 1", cfg_err); end
      @(posedge clk); #1;
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL busy_cfg_err_clear: got %b want 0", cfg_err); end
      n = 0;
      while (!bus_if.out_valid && n < 100) begin @(posedge clk); #1; n++; end
      got = bus_if.out_mask;
      exp = exp_q.pop_front();
      checks++;
      if (!bus_if.out_valid || got !== exp) begin errors++; $display("FAIL busy_mask: got %h want %h", got, exp); end
      bus_if.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.out_ready = 1'b0;
      $display("busy eval mask=%h cfg_err pulsed", got);
      // Entry 0 updated in the model to edge 2 above; bit 2 only when vec bit0=1.
      masks[0] = 8'h20; masks[1] = 8'h24;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(masks[k]);
         do_eval(vecs[k], -1, got, lat, tmo);
         exp = exp_q.pop_front();
         checks++;
         if (tmo || got !== exp || lat != 4) begin
            errors++; $display("FAIL busy_readback[%0d]: got %h lat %0d want %h lat 4", k, got, lat, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [N_EDGES-1:0] got, exp;
      logic [IN_W-1:0] v;
      int lat, elat, c;
      bit tmo;
      for (int a = 0; a < DEPTH; a++) begin
         cfg_write(a, 15'($urandom & $urandom & $urandom), 15'($urandom), $urandom_range(0, N_EDGES - 1));
      end
      set_count(300);
      for (int k = 0; k < 8; k++) begin
         if (k > 0 && k < 7) begin
            c = $urandom_range(1, 40);
            set_count(c);
         end
         v = 15'($urandom);
         if (k == 7) begin
            m_count = 5;
            exp_q.push_back(model_eval(v)); lat_q.push_back(6);
            do_eval(v, 5, got, lat, tmo);
         end else begin
            exp_q.push_back(model_eval(v)); lat_q.push_back(m_count + 1);
            do_eval(v, -1, got, lat, tmo);
         end
         exp = exp_q.pop_front(); elat = lat_q.pop_front();
         checks++;
         if (tmo || got !== exp) begin errors++; $display("FAIL b2b_mask[%0d]: got %h want %h", k, got, exp); end
         checks++;
         if (lat != elat) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", k, lat, elat); end
      end
   endtask

   task automatic test_reset_mid_scan();
      logic [N_EDGES-1:0] got, exp;
      int lat;
      bit tmo;
      set_count(200);
      bus_if.in_valid = 1'b1;
      bus_if.in_vec   = 15'h2AAA;
      @(posedge clk); #1;
      bus_if.in_valid = 1'b0;
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", bus_if.in_ready); end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d]: got %b want 0", c, bus_if.out_valid); end
      end
      rst = 1'b0;
      m_count = 0;
      #1;
      checks++;
      if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_release: in_ready=%b out_valid=%b want 1 0", bus_if.in_ready, bus_if.out_valid);
      end
      @(posedge clk); #1;
      exp_q.push_back(model_eval(15'h7FFF)); lat_q.push_back(1);
      do_eval(15'h7FFF, -1, got, lat, tmo);
      exp = exp_q.pop_front();
      checks++;
      if (tmo || got !== exp || lat != lat_q.pop_front()) begin
         errors++; $display("FAIL midrst_eval: got %h lat %0d want %h lat 1", got, lat, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_edge = '0;
      cfg_count_we = 1'b0; cfg_count = '0;
      bus_if.in_valid = 1'b0; bus_if.in_vec = '0; bus_if.out_ready = 1'b0;
      test_reset();
      test_empty();
      test_single_cube();
      test_multi_edge();
      test_backpressure();
      test_cfg_busy();
      test_back_to_back();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
      $fatal(1, "watchdog");
   end
endmodule
